// File: rtl/phase_seq_ctrl.sv
// phase_seq_ctrl: multi-phase sequence controller with run-time programmable
// per-phase durations, hold/pause, completed-cycle counter and duration load.
// Optional feature: define PHASE_SEQ_PRESCALE_EN to divide the tick by PRESCALE.
module phase_seq_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned N_PHASE     = 4,
  parameter int unsigned DEFAULT_DUR = 3,
  parameter int unsigned CYC_W       = 4,
  parameter int unsigned PRESCALE    = 4,
  localparam int unsigned IDX_W      = $clog2(N_PHASE)
) (
  input  logic               CK,
  input  logic               RST,
  input  logic               EN,
  input  logic               HOLD,
  input  logic               LOAD,
  input  logic [IDX_W-1:0]   LOAD_IDX,
  input  logic [CNT_W-1:0]   LOAD_VAL,
  output logic [IDX_W-1:0]   PHASE,
  output logic [N_PHASE-1:0] PHASE_OH,
  output logic [CNT_W-1:0]   CNT,
  output logic               PH_DONE,
  output logic               CYC_DONE,
  output logic [CYC_W-1:0]   CYC_CNT,
  output logic               BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  if (N_PHASE < 2 || PRESCALE < 1) begin : g_bad_param
    $error("phase_seq_ctrl: N_PHASE must be >= 2 and PRESCALE >= 1");
  end

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_phase, w_phase_nxt;
  logic [N_PHASE-1:0] r_phase_oh, w_phase_oh_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_ph_done, w_ph_done_nxt;
  logic               r_cyc_done, w_cyc_done_nxt;
  logic [CYC_W-1:0]   r_cyc_cnt, w_cyc_cnt_nxt;
  logic               r_busy;
  logic [CNT_W-1:0]   r_dur [N_PHASE];
  logic               w_run_active;
  logic               w_tick;
  logic               w_load_ok;

  // counting is only live in RUN with EN high and HOLD low
  assign w_run_active = (r_state == S_RUN) && EN && !HOLD;
  assign w_load_ok    = LOAD && ({{(32-IDX_W){1'b0}}, LOAD_IDX} < N_PHASE);

`ifdef PHASE_SEQ_PRESCALE_EN
  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PS_W-1:0] r_pre;

  assign w_tick = w_run_active && (r_pre == PS_W'(PRESCALE - 1));

  // prescaler: cleared outside RUN/PAUSE so RUN entry starts fresh, frozen in PAUSE
  always_ff @(posedge CK) begin
    if (RST || !EN || r_state == S_IDLE) begin
      r_pre <= '0;
    end else if (w_run_active) begin
      r_pre <= w_tick ? '0 : r_pre + PS_W'(1);
    end
  end
`else
  assign w_tick = w_run_active;
`endif

  // state register
  always_ff @(posedge CK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state and next registered-output values
  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_cnt_nxt      = r_cnt;
    w_ph_done_nxt  = 1'b0;
    w_cyc_done_nxt = 1'b0;
    w_cyc_cnt_nxt  = r_cyc_cnt;
    w_phase_oh_nxt = '0;
    case (r_state)
      S_IDLE: begin
        w_phase_nxt = '0;
        w_cnt_nxt   = '0;
        if (EN) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!EN) begin
          w_state_nxt = S_IDLE;
          w_phase_nxt = '0;
          w_cnt_nxt   = '0;
        end else if (HOLD) begin
          w_state_nxt = S_PAUSE;
        end else if (w_tick) begin
          if (r_cnt >= r_dur[r_phase]) begin
            w_cnt_nxt     = '0;
            w_ph_done_nxt = 1'b1;
            if (r_phase == IDX_W'(N_PHASE - 1)) begin
              w_phase_nxt    = '0;
              w_cyc_done_nxt = 1'b1;
              w_cyc_cnt_nxt  = r_cyc_cnt + CYC_W'(1);
            end else begin
              w_phase_nxt = r_phase + IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_PAUSE: begin
        if (!EN) begin
          w_state_nxt = S_IDLE;
          w_phase_nxt = '0;
          w_cnt_nxt   = '0;
        end else if (!HOLD) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
    if (w_state_nxt != S_IDLE) begin
      for (int unsigned i = 0; i < N_PHASE; i++) begin
        w_phase_oh_nxt[i] = ({{(32-IDX_W){1'b0}}, w_phase_nxt} == i);
      end
    end
  end

  // registered outputs
  always_ff @(posedge CK) begin
    if (RST) begin
      r_phase    <= '0;
      r_phase_oh <= '0;
      r_cnt      <= '0;
      r_ph_done  <= 1'b0;
      r_cyc_done <= 1'b0;
      r_cyc_cnt  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_phase    <= w_phase_nxt;
      r_phase_oh <= w_phase_oh_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ph_done  <= w_ph_done_nxt;
      r_cyc_done <= w_cyc_done_nxt;
      r_cyc_cnt  <= w_cyc_cnt_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  // duration registers: loadable in any state, out-of-range index ignored
  always_ff @(posedge CK) begin
    if (RST) begin
      for (int unsigned i = 0; i < N_PHASE; i++) r_dur[i] <= CNT_W'(DEFAULT_DUR);
    end else if (w_load_ok) begin
      r_dur[LOAD_IDX] <= LOAD_VAL;
    end
  end

  assign PHASE    = r_phase;
  assign PHASE_OH = r_phase_oh;
  assign CNT      = r_cnt;
  assign PH_DONE  = r_ph_done;
  assign CYC_DONE = r_cyc_done;
  assign CYC_CNT  = r_cyc_cnt;
  assign BUSY     = r_busy;

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// Directed self-checking bench for phase_seq_ctrl at default parameters.
module tb_phase_seq_ctrl;

  logic       CK = 1'b0;
  logic       RST, EN, HOLD, LOAD;
  logic [1:0] LOAD_IDX;
  logic [7:0] LOAD_VAL;
  logic [1:0] PHASE;
  logic [3:0] PHASE_OH;
  logic [7:0] CNT;
  logic       PH_DONE, CYC_DONE, BUSY;
  logic [3:0] CYC_CNT;

  int errors = 0;
  int checks = 0;

  phase_seq_ctrl #(.CNT_W(8), .N_PHASE(4), .DEFAULT_DUR(3), .CYC_W(4), .PRESCALE(4)) dut (
    .CK(CK), .RST(RST), .EN(EN), .HOLD(HOLD), .LOAD(LOAD),
    .LOAD_IDX(LOAD_IDX), .LOAD_VAL(LOAD_VAL),
    .PHASE(PHASE), .PHASE_OH(PHASE_OH), .CNT(CNT),
    .PH_DONE(PH_DONE), .CYC_DONE(CYC_DONE), .CYC_CNT(CYC_CNT), .BUSY(BUSY)
  );

  always #5 CK = ~CK;

  // observed status: {PHASE, PHASE_OH, CNT, PH_DONE, CYC_DONE, CYC_CNT, BUSY}
  logic [20:0] w_obs;
  assign w_obs = {PHASE, PHASE_OH, CNT, PH_DONE, CYC_DONE, CYC_CNT, BUSY};

  function automatic logic [20:0] pk(int ph, int cnt, bit phd, bit cyd, int cyc, bit busy);
    logic [3:0] oh;
    oh = busy ? 4'(1 << ph) : 4'b0000;
    return {2'(ph), oh, 8'(cnt), phd, cyd, 4'(cyc), busy};
  endfunction

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; EN = 1'b0; HOLD = 1'b0; LOAD = 1'b0; LOAD_IDX = '0; LOAD_VAL = '0;
    step(); step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] exp;
    RST = 1'b1; EN = 1'b0; HOLD = 1'b0;
    LOAD = 1'b1; LOAD_IDX = 2'd0; LOAD_VAL = 8'd0;   // must be ignored under reset
    step(); step();
    exp = pk(0, 0, 0, 0, 0, 0);
    checks++;
    if (w_obs !== exp) begin
      errors++; $display("FAIL reset_state: got %h expected %h", w_obs, exp);
    end
    RST = 1'b0; LOAD = 1'b0; EN = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      exp = (k <= 4) ? pk(0, k - 1, 0, 0, 0, 1) : pk(1, 0, 1, 0, 0, 1);
      checks++;
      if (w_obs !== exp) begin
        errors++; $display("FAIL load_in_reset k=%0d: got %h expected %h", k, w_obs, exp);
      end
    end
  endtask

  task automatic test_run();
    logic [20:0] exp;
    int t;
    do_reset();
    EN = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      step();
      t = k - 1;
      exp = pk((t / 4) % 4, t % 4, (t > 0) && (t % 4 == 0), (t > 0) && (t % 16 == 0),
               (t / 16) % 16, 1);
      checks++;
      if (w_obs !== exp) begin
        errors++; $display("FAIL run t=%0d: got %h expected %h", t, w_obs, exp);
      end
    end
  endtask

  task automatic test_load();
    logic [20:0] exp;
    do_reset();
    EN = 1'b1;
    step();                                    // phase 0, cnt 0
    LOAD = 1'b1; LOAD_IDX = 2'd2; LOAD_VAL = 8'd0;
    step();                                    // cnt 1
    LOAD = 1'b0;
    for (int k = 3; k <= 14; k++) begin
      step();
      case (k)
        4:       exp = pk(0, 3, 0, 0, 0, 1);
        5:       exp = pk(1, 0, 1, 0, 0, 1);
        8:       exp = pk(1, 3, 0, 0, 0, 1);
        9:       exp = pk(2, 0, 1, 0, 0, 1);
        10:      exp = pk(3, 0, 1, 0, 0, 1);
        13:      exp = pk(3, 3, 0, 0, 0, 1);
        14:      exp = pk(0, 0, 1, 1, 1, 1);
        default: exp = w_obs;
      endcase
      if (k inside {4, 5, 8, 9, 10, 13, 14}) begin
        checks++;
        if (w_obs !== exp) begin
          errors++; $display("FAIL load_dur k=%0d: got %h expected %h", k, w_obs, exp);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [20:0] exp;
    do_reset();
    EN = 1'b1;
    step(); step(); step();                    // cnt 2
    HOLD = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      exp = pk(0, 2, 0, 0, 0, 1);
      checks++;
      if (w_obs !== exp) begin
        errors++; $display("FAIL hold_freeze k=%0d: got %h expected %h", k, w_obs, exp);
      end
    end
    HOLD = 1'b0;
    step();                                    // back to RUN, still cnt 2
    step();
    exp = pk(0, 3, 0, 0, 0, 1);
    checks++;
    if (w_obs !== exp) begin
      errors++; $display("FAIL hold_resume: got %h expected %h", w_obs, exp);
    end
    step();
    exp = pk(1, 0, 1, 0, 0, 1);
    checks++;
    if (w_obs !== exp) begin
      errors++; $display("FAIL hold_phase_end: got %h expected %h", w_obs, exp);
    end
    step();                                    // phase 1, cnt 1
    EN = 1'b0;
    step();
    exp = pk(0, 0, 0, 0, 0, 0);
    checks++;
    if (w_obs !== exp) begin
      errors++; $display("FAIL en_low_idle: got %h expected %h", w_obs, exp);
    end
    EN = 1'b1;
    step(); step();                            // RUN, cnt 1
    EN = 1'b0; HOLD = 1'b1;
    step();
    exp = pk(0, 0, 0, 0, 0, 0);
    checks++;
    if (w_obs !== exp) begin
      errors++; $display("FAIL en_beats_hold: got %h expected %h", w_obs, exp);
    end
    HOLD = 1'b0;
  endtask

  task automatic test_shrink();
    logic [20:0] exp;
    do_reset();
    LOAD = 1'b1; LOAD_IDX = 2'd1; LOAD_VAL = 8'd5;
    step();                                    // load while idle
    LOAD = 1'b0; EN = 1'b1;
    for (int k = 1; k <= 8; k++) step();       // phase 1, cnt 3
    exp = pk(1, 3, 0, 0, 0, 1);
    checks++;
    if (w_obs !== exp) begin
      errors++; $display("FAIL shrink_pre: got %h expected %h", w_obs, exp);
    end
    LOAD = 1'b1; LOAD_IDX = 2'd1; LOAD_VAL = 8'd1;
    step();                                    // compare still sees DUR=5
    LOAD = 1'b0;
    exp = pk(1, 4, 0, 0, 0, 1);
    checks++;
    if (w_obs !== exp) begin
      errors++; $display("FAIL shrink_load_edge: got %h expected %h", w_obs, exp);
    end
    step();
    exp = pk(2, 0, 1, 0, 0, 1);
    checks++;
    if (w_obs !== exp) begin
      errors++; $display("FAIL shrink_end: got %h expected %h", w_obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; HOLD = 1'b0; LOAD = 1'b0; LOAD_IDX = '0; LOAD_VAL = '0;
    test_reset();
    test_run();
    test_load();
    test_hold();
    test_shrink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
